// File: rtl/icache_dm_if.sv
// icache_dm_if
//   Refill bus between the instruction cache and instruction memory.
//   The cache drives a request with the line base address and holds both
//   until the memory grants.
//   The memory then returns one word per mem_rvalid beat, in ascending word order.
// Signals
//   mem_req     cache -> mem   refill request
//   mem_addr    cache -> mem   line base address of the refill
//   mem_gnt     mem -> cache   request accepted (meaningful while mem_req=1)
//   mem_rvalid  mem -> cache   one refill word on mem_rdata this cycle
//   mem_rdata   mem -> cache   refill data
// Modports
//   master  cache side
//   slave   memory side
interface icache_dm_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/icache_dm.sv
// icache_dm
//   Direct-mapped, read-only instruction cache in front of the fetch stage.
//   Lookup is combinational from PCF. A miss raises IMissF, which stalls fetch.
//   It then refills the whole line over the req/gnt + rvalid bus in icache_dm_if.
// Parameters
//   LINES  number of lines (power of 2, >= 2)
//   WORDS  32-bit words per line (power of 2, >= 2)
// Ports
//   clk     clock, all state changes on the rising edge
//   reset   synchronous, active-high reset
//   PCF     fetch address; bits [1:0] are ignored
//   InstrF  instruction for PCF (NOP when not a hit); valid when IMissF=0
//   IMissF  miss or refill in progress
//   mem     refill bus, master side
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic        IMissF,
    icache_dm_if.master mem
);

    localparam int WRD_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF   = WRD_W + 2;
    localparam int TAG_W = 32 - OFF - IDX_W;

    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
    localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    // Storage. Only the valid bits need a reset value.
    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      data_r [LINES][WORDS];

    // Refill bookkeeping
    state_t           state_r;
    state_t           state_s;
    logic [WRD_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [TAG_W-1:0] tag_lat_r;
    logic             req_r;
    logic [31:0]      addr_r;

    // Lookup fields and FSM strobes
    logic [IDX_W-1:0] idx_s;
    logic [WRD_W-1:0] word_s;
    logic [TAG_W-1:0] tag_s;
    logic             hit_s;
    logic             start_s;
    logic             beat_s;
    logic             last_s;

    // Byte-offset bits of the PC never take part in the lookup.
    logic             unused_s;

    assign idx_s    = PCF[OFF+IDX_W-1:OFF];
    assign word_s   = PCF[OFF-1:2];
    assign tag_s    = PCF[31:OFF+IDX_W];
    assign unused_s = ^PCF[1:0];
    assign hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

    assign mem.mem_req  = req_r;
    assign mem.mem_addr = addr_r;

    // Fetch-side outputs: zero-latency lookup.
    // A refill in flight stalls fetch even when PCF happens to hit another line.
    always_comb begin
        InstrF = NOP_INSTR;
        if (hit_s) begin
            InstrF = data_r[idx_s][word_s];
        end else begin
            InstrF = NOP_INSTR;
        end
        IMissF = (~hit_s) || (state_r != IDLE);
    end

    // Next-state logic and per-cycle refill strobes
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        beat_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!hit_s) begin
                    start_s = 1'b1;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    state_s = FILL;
                end else begin
                    state_s = REQ;
                end
            end
            FILL: begin
                // Gap cycles (rvalid=0) simply wait.
                if (mem.mem_rvalid) begin
                    beat_s = 1'b1;
                    if (cnt_r == LAST_BEAT) begin
                        last_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state: FSM, beat counter, request/address registers, valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {WRD_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            tag_lat_r <= {TAG_W{1'b0}};
            req_r     <= 1'b0;
            addr_r    <= 32'h0000_0000;
            valid_r   <= {LINES{1'b0}};
        end else begin
            state_r <= state_s;
            if (start_s) begin
                // The victim line is invalidated up front.
                // A refill abandoned by reset therefore never exposes half a line.
                valid_r[idx_s] <= 1'b0;
                idx_r          <= idx_s;
                tag_lat_r      <= tag_s;
                addr_r         <= {PCF[31:OFF], {OFF{1'b0}}};
                cnt_r          <= {WRD_W{1'b0}};
                req_r          <= 1'b1;
            end else if ((state_r == REQ) && mem.mem_gnt) begin
                req_r <= 1'b0;
            end else if (beat_s) begin
                cnt_r <= cnt_r + WRD_W'(1);
                if (last_s) begin
                    valid_r[idx_r] <= 1'b1;
                end
            end
        end
    end

    // Data and tag arrays: written only by refill beats, never reset
    always_ff @(posedge clk) begin
        if (beat_s && !reset) begin
            data_r[idx_r][cnt_r] <= mem.mem_rdata;
            if (last_s) begin
                tag_r[idx_r] <= tag_lat_r;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm
//   Directed bench for icache_dm (LINES=16, WORDS=4).
//   A line-level model keeps, per index, the line number it holds (-1 when empty).
//   It also tracks whether a refill is outstanding, whether that refill has been granted,
//   and which words have arrived.
//   On every falling edge the cache outputs are compared with the model.
//   Directed steps add hand-computed literal expectations.
module tb_icache_dm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] PCF    = 32'h0000_0000;
    logic [31:0] InstrF;
    logic        IMissF;

    icache_dm_if bus();

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .PCF    (PCF),
        .InstrF (InstrF),
        .IMissF (IMissF),
        .mem    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_line [16];
    logic [31:0] m_data [16][4];
    logic [31:0] fbuf [4];
    bit          busy    = 1'b0;
    bit          granted = 1'b0;
    bit          ready   = 1'b0;
    int          fcnt    = 0;
    int          p_line  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        int ln;
        ln = int'(a >> 4);
        return m_line[ln % 16] == ln;
    endfunction

    // Model update on each rising edge, from the inputs the cache samples there
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_line[i] = -1;
            busy    = 1'b0;
            granted = 1'b0;
            fcnt    = 0;
            ready   = 1'b1;
        end else if (!busy) begin
            if (!m_hit(PCF)) begin
                busy    = 1'b1;
                granted = 1'b0;
                fcnt    = 0;
                p_line  = int'(PCF >> 4);
                m_line[p_line % 16] = -1;
            end
        end else if (!granted) begin
            if (bus.mem_gnt) granted = 1'b1;
        end else if (bus.mem_rvalid) begin
            fbuf[fcnt] = bus.mem_rdata;
            fcnt++;
            if (fcnt == 4) begin
                m_line[p_line % 16] = p_line;
                for (int k = 0; k < 4; k++) m_data[p_line % 16][k] = fbuf[k];
                busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int          ln;
        bit          e_hit;
        logic [31:0] e_instr;
        if (ready) begin
            ln      = int'(PCF >> 4);
            e_hit   = (m_line[ln % 16] == ln);
            e_instr = e_hit ? m_data[ln % 16][PCF[3:2]] : NOP;
            check("cyc_IMissF", {31'd0, IMissF}, {31'd0, (!e_hit) || busy});
            check("cyc_InstrF", InstrF, e_instr);
            check("cyc_mem_req", {31'd0, bus.mem_req}, {31'd0, busy && !granted});
            if (busy && !granted) check("cyc_mem_addr", bus.mem_addr, 32'(p_line) << 4);
        end
    end

    // One cycle: apply inputs just after the rising edge and return at the falling edge
    task automatic drive(input logic r, input logic [31:0] pc, input logic g,
                         input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        reset          = r;
        PCF            = pc;
        bus.mem_gnt    = g;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rd;
        @(negedge clk);
    endtask

    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        // Reset, then cold miss on 0x0
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rst_IMissF", {31'd0, IMissF}, 32'd1);
        check("rst_InstrF", InstrF, 32'h0000_0013);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t1_mem_req", {31'd0, bus.mem_req}, 32'd1);
        check("t1_mem_addr", bus.mem_addr, 32'h0);
        for (int k = 0; k < 4; k++) drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA0 + 32'(k));
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t1_hit_IMissF", {31'd0, IMissF}, 32'd0);
        check("t1_hit_InstrF", InstrF, 32'hA0);

        // Hits on the rest of the line
        drive(1'b0, 32'h4, 1'b0, 1'b0, 32'h0);
        check("t2_w1", InstrF, 32'hA1);
        drive(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
        check("t2_w2", InstrF, 32'hA2);
        check("t2_req", {31'd0, bus.mem_req}, 32'd0);
        drive(1'b0, 32'hC, 1'b0, 1'b0, 32'h0);
        check("t2_w3", InstrF, 32'hA3);
        check("t2_miss", {31'd0, IMissF}, 32'd0);

        // Conflict: 0x100 evicts line 0
        drive(1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
        check("t3_miss", {31'd0, IMissF}, 32'd1);
        drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h0);
        check("t3_addr", bus.mem_addr, 32'h100);
        for (int k = 0; k < 4; k++) drive(1'b0, 32'h100, 1'b0, 1'b1, 32'hB0 + 32'(k));
        drive(1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
        check("t3_hit", InstrF, 32'hB0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t3_remiss", {31'd0, IMissF}, 32'd1);

        // Grant delay of 3 cycles, then beats with gaps
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            check("t4_wait_req", {31'd0, bus.mem_req}, 32'd1);
            check("t4_wait_addr", bus.mem_addr, 32'h0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        begin
            logic [6:0] pat;
            int         nb;
            pat = 7'b1101001;  // bit 0 first: 1,0,0,1,0,1,1
            nb  = 0;
            for (int k = 0; k < 7; k++) begin
                if (pat[k]) begin
                    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hF0 + 32'(nb));
                    nb++;
                end else begin
                    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'hBAD);
                end
                check("t4_fill_miss", {31'd0, IMissF}, 32'd1);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t4_w0", InstrF, 32'hF0);
        drive(1'b0, 32'h4, 1'b0, 1'b0, 32'h0);
        check("t4_w1", InstrF, 32'hF1);
        drive(1'b0, 32'hC, 1'b0, 1'b0, 32'h0);
        check("t4_w3", InstrF, 32'hF3);

        // Reset in the middle of a refill of 0x40
        drive(1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h40, 1'b0, 1'b1, 32'hC0);
        drive(1'b0, 32'h40, 1'b0, 1'b1, 32'hC1);
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h40, 1'b0, 1'b1, 32'hDEAD);
        check("t5_req_off", {31'd0, bus.mem_req}, 32'd0);
        check("t5_miss", {31'd0, IMissF}, 32'd1);
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
        check("t5_req", {31'd0, bus.mem_req}, 32'd1);
        check("t5_addr", bus.mem_addr, 32'h40);
        for (int k = 0; k < 4; k++) drive(1'b0, 32'h40, 1'b0, 1'b1, 32'hC0 + 32'(k));
        drive(1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
        check("t5_w0", InstrF, 32'hC0);
        drive(1'b0, 32'h44, 1'b0, 1'b0, 32'h0);
        check("t5_w1", InstrF, 32'hC1);

        // Redirect from 0x20 to 0x300 while line 0x20 is filling
        drive(1'b0, 32'h20, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h20, 1'b1, 1'b0, 32'h0);
        check("t6_addr20", bus.mem_addr, 32'h20);
        drive(1'b0, 32'h20, 1'b0, 1'b1, 32'hD0);
        for (int k = 1; k < 4; k++) begin
            drive(1'b0, 32'h300, 1'b0, 1'b1, 32'hD0 + 32'(k));
            check("t6_redir_miss", {31'd0, IMissF}, 32'd1);
        end
        drive(1'b0, 32'h300, 1'b0, 1'b0, 32'h0);
        check("t6_300_miss", {31'd0, IMissF}, 32'd1);
        drive(1'b0, 32'h300, 1'b1, 1'b0, 32'h0);
        check("t6_addr300", bus.mem_addr, 32'h300);
        check("t6_req300", {31'd0, bus.mem_req}, 32'd1);
        for (int k = 0; k < 4; k++) drive(1'b0, 32'h300, 1'b0, 1'b1, 32'hE0 + 32'(k));
        drive(1'b0, 32'h300, 1'b0, 1'b0, 32'h0);
        check("t6_300_hit", InstrF, 32'hE0);
        drive(1'b0, 32'h20, 1'b0, 1'b0, 32'h0);
        check("t6_20_hit", {31'd0, IMissF}, 32'd0);
        check("t6_20_w0", InstrF, 32'hD0);
        drive(1'b0, 32'h2C, 1'b0, 1'b0, 32'h0);
        check("t6_20_w3", InstrF, 32'hD3);

        drive(1'b0, 32'h2C, 1'b0, 1'b0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
